// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer.
//   deb_state_e              : per-channel debounce FSM state
//   DEFAULT_DEBOUNCE_CYCLES  : default number of stable samples to accept a level
//   cnt_width()              : width of the per-channel stability counter
package switch_debouncer_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'b00,
        ST_CHECK_HIGH  = 2'b01,
        ST_STABLE_HIGH = 2'b10,
        ST_CHECK_LOW   = 2'b11
    } deb_state_e;

    // Counter only has to reach cycles-1, so clog2(cycles) bits are enough.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One debounce channel: 2-flop synchronizer, debounce FSM and stability counter.
//   clk_i   : system clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   raw_i   : asynchronous raw switch level
//   level_o : debounced level (registered)
//   rise_o  : one-cycle pulse on accepted 0->1 (registered)
//   fall_o  : one-cycle pulse on accepted 1->0 (registered)
module switch_debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             meta_q;
    logic             sync_q;
    deb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // Two-flop synchronizer; only sync_q is allowed to reach the FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Debounce FSM with counter and registered level/edge outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_STABLE_LOW: begin
                    if (sync_q) begin
                        state_q <= ST_CHECK_HIGH;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_STABLE_LOW;
                    end
                end
                ST_CHECK_HIGH: begin
                    if (!sync_q) begin
                        state_q <= ST_STABLE_LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        // Counter never wraps: acceptance leaves the CHECK state.
                        state_q <= ST_STABLE_HIGH;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE_HIGH: begin
                    if (!sync_q) begin
                        state_q <= ST_CHECK_LOW;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_STABLE_HIGH;
                    end
                end
                ST_CHECK_LOW: begin
                    if (sync_q) begin
                        state_q <= ST_STABLE_HIGH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_STABLE_LOW;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_STABLE_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer.
//   SYSTEMCLOCK           : system clock, rising edge
//   PUSH_BUTTON_RESET_RAW : asynchronous active-low reset
//   switch_raw            : asynchronous raw switch levels, bit i = channel i
//   switch_level          : debounced level per channel
//   switch_rise           : one-cycle pulse per channel on accepted 0->1
//   switch_fall           : one-cycle pulse per channel on accepted 1->0
//   switch_changed        : OR of all rise/fall pulses, same cycle
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int NUM_SWITCHES    = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    SYSTEMCLOCK,
    input  logic                    PUSH_BUTTON_RESET_RAW,
    input  logic [NUM_SWITCHES-1:0] switch_raw,
    output logic [NUM_SWITCHES-1:0] switch_level,
    output logic [NUM_SWITCHES-1:0] switch_rise,
    output logic [NUM_SWITCHES-1:0] switch_fall,
    output logic                    switch_changed
);

    for (genvar gi = 0; gi < NUM_SWITCHES; gi++) begin : g_chan
        switch_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i   (SYSTEMCLOCK),
            .rst_ni  (PUSH_BUTTON_RESET_RAW),
            .raw_i   (switch_raw[gi]),
            .level_o (switch_level[gi]),
            .rise_o  (switch_rise[gi]),
            .fall_o  (switch_fall[gi])
        );
    end

    // Built only from registered pulses, so there is no path from switch_raw.
    assign switch_changed = |(switch_rise | switch_fall);

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter NUM_SWITCHES, default 4, giving the number of independent switch channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of consecutive stable synchronized samples needed to accept a new level; legal range is 2 or more.
REQ-003 SYSTEMCLOCK  input  1  single system clock; all state is on its rising edge.
REQ-004 PUSH_BUTTON_RESET_RAW  input  1  reset, asynchronous assert, active-low.
REQ-005 switch_raw  input  NUM_SWITCHES  asynchronous raw switch levels; bit i is channel i.
REQ-006 switch_level  output  NUM_SWITCHES  debounced level per channel.
REQ-007 switch_rise  output  NUM_SWITCHES  one-cycle pulse when the debounced level goes 0->1.
REQ-008 switch_fall  output  NUM_SWITCHES  one-cycle pulse when the debounced level goes 1->0.
REQ-009 switch_changed  output  1  OR-reduction of (switch_rise | switch_fall), same cycle.

Function
REQ-010 Each switch_raw bit SHALL pass through a 2-flop synchronizer; only the second flop (sync) feeds the FSM.
REQ-011 Each channel SHALL run an independent FSM: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
REQ-012 In STABLE_LOW with sync=1, the FSM SHALL go to CHECK_HIGH with the counter cleared to 0; with sync=0 it SHALL stay.
REQ-013 In CHECK_HIGH with sync=0, the FSM SHALL return to STABLE_LOW and emit no pulse.
REQ-014 In CHECK_HIGH with sync=1 and count < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 In CHECK_HIGH with sync=1 and count = DEBOUNCE_CYCLES-1, the FSM SHALL go to STABLE_HIGH, set switch_level=1, and assert switch_rise for exactly one cycle.
REQ-016 STABLE_HIGH and CHECK_LOW SHALL mirror REQ-012 to REQ-015 with polarity inverted; acceptance sets switch_level=0 and pulses switch_fall.
REQ-017 Latency: a raw change sampled at edge k and held stable SHALL update switch_level and pulse switch_rise or switch_fall at edge k+2+DEBOUNCE_CYCLES.
REQ-018 A glitch whose synchronized width is shorter than DEBOUNCE_CYCLES SHALL cause no change on any output.
REQ-019 The counter width SHALL be clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap and SHALL saturate only by leaving the CHECK state.
REQ-020 switch_rise and switch_fall SHALL never both be asserted on the same channel in the same cycle.
REQ-021 Channels SHALL be fully independent; simultaneous acceptance on several channels SHALL pulse all of them in the same cycle.
REQ-022 All outputs SHALL be registered, with no combinational path from switch_raw to any output.

Reset
REQ-023 While PUSH_BUTTON_RESET_RAW=0, the block SHALL hold all of the following: synchronizer flops=0, FSM=STABLE_LOW, counters=0, switch_level=0, switch_rise=0, switch_fall=0, switch_changed=0.
REQ-024 Reset asserted mid-CHECK SHALL abort the count with no pulse.
REQ-025 After reset release, an input already held high SHALL produce switch_rise DEBOUNCE_CYCLES+2 cycles after the first post-reset edge.

Structure
REQ-026 A shared package SHALL hold the debounce FSM state enum and the default DEBOUNCE_CYCLES constant.
REQ-027 The per-channel synchronizer, FSM and counter SHALL be a sub-module switch_debounce_channel, instantiated NUM_SWITCHES times by a generate loop; switch_changed SHALL be formed in the top.

Verification (DEBOUNCE_CYCLES=4, NUM_SWITCHES=4)
REQ-028 Raw bit0 0->1 at edge 10, held high -> switch_level[0]=1 and a single switch_rise[0] pulse at edge 16, with switch_changed=1 at edge 16 only.
REQ-029 Raw bit1 high for 3 cycles, then low -> no output change ever.
REQ-030 Raw bit2 toggles every cycle for 20 cycles, then settles high -> exactly one switch_rise[2], 6 cycles after it settles.
REQ-031 Bits 0 and 3 rise at the same edge -> switch_rise=4'b1001 in a single cycle.
REQ-032 Bit0 high, reset asserted 2 cycles into CHECK_HIGH and released 5 cycles later -> no pulse during reset, then switch_rise[0] 6 cycles after release.
REQ-033 Bit0 accepted high, then raw falls and is held low -> switch_fall[0] pulses 6 cycles later and switch_level[0]=0.
